// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler that shares one UART transmit engine between two
// byte requesters. A granted byte is presented on tx_data, a start strobe
// is generated on tx_trig (the engine starts on its falling edge), the
// engine busy flag is tracked until the frame completes, and a guard gap
// is enforced before the next grant.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable the busy-rise
// (START_TO) and busy-fall (DONE_TO) timeouts that abort a frame with err.
// Without the macro the wait states wait indefinitely and err stays 0.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req0/1    requester has a byte (held until its ack)
//   data0/1   requester byte, stable while its req is high
//   ack0/1    one-cycle pulse, byte accepted
//   tx_data   byte presented to the engine, held until the next grant
//   tx_trig   start strobe, high for TRIG_LEN cycles
//   tx_busy   engine busy flag, high during a frame
//   grant_id  requester owning the current/last frame
//   active    high whenever the arbiter is not idle
//   done      one-cycle pulse, frame completed normally
//   err       one-cycle pulse, timeout abort
module uart_tx_arbiter #(
  parameter int TRIG_LEN = 4,
  parameter int GAP_CYC  = 2,
  parameter int START_TO = 16,
  parameter int DONE_TO  = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       tx_trig,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       active,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  // Last counter value of each timed state; GAP_CYC=0 still spends one cycle in GAP.
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_LEN - 1);
  localparam logic [15:0] GAP_LAST  = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

  state_t      state_r, next_state_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic        last_grant_r, last_grant_nxt_s;
  logic        grant_s, pick_s;
  logic        start_to_s, done_to_s;

  logic        ack0_r, ack0_nxt_s;
  logic        ack1_r, ack1_nxt_s;
  logic [7:0]  tx_data_r, tx_data_nxt_s;
  logic        tx_trig_r, tx_trig_nxt_s;
  logic        grant_id_r, grant_id_nxt_s;
  logic        active_r, active_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] START_LIM = 16'(START_TO);
  localparam logic [15:0] DONE_LIM  = 16'(DONE_TO);
  assign start_to_s = (cnt_r == START_LIM);
  assign done_to_s  = (cnt_r == DONE_LIM);
`else
  localparam logic [15:0] START_LIM = 16'(START_TO);
  localparam logic [15:0] DONE_LIM  = 16'(DONE_TO);
  logic unused_s;
  assign start_to_s = 1'b0;
  assign done_to_s  = 1'b0;
  assign unused_s   = ^{START_LIM, DONE_LIM};
`endif

  // A grant needs a pending request and an idle engine; on a tie the
  // requester that did not own the last frame wins.
  assign grant_s = (req0 | req1) & ~tx_busy;
  assign pick_s  = (req0 & req1) ? ~last_grant_r : req1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_s) next_state_s = S_TRIG;
        else         next_state_s = S_IDLE;
      end
      S_TRIG: begin
        if (cnt_r == TRIG_LAST) next_state_s = S_WAIT_BUSY;
        else                    next_state_s = S_TRIG;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)         next_state_s = S_WAIT_DONE;
        else if (start_to_s) next_state_s = S_GAP;
        else                 next_state_s = S_WAIT_BUSY;
      end
      S_WAIT_DONE: begin
        if (!tx_busy)       next_state_s = S_GAP;
        else if (done_to_s) next_state_s = S_GAP;
        else                next_state_s = S_WAIT_DONE;
      end
      S_GAP: begin
        if (cnt_r == GAP_LAST) next_state_s = S_IDLE;
        else                   next_state_s = S_GAP;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output and counter next values; everything is registered below.
  always_comb begin
    ack0_nxt_s       = 1'b0;
    ack1_nxt_s       = 1'b0;
    tx_data_nxt_s    = tx_data_r;
    grant_id_nxt_s   = grant_id_r;
    last_grant_nxt_s = last_grant_r;
    done_nxt_s       = 1'b0;
    err_nxt_s        = 1'b0;
    tx_trig_nxt_s    = (next_state_s == S_TRIG);
    active_nxt_s     = (next_state_s != S_IDLE);

    // Counter restarts from zero on every state change and saturates.
    if (next_state_s != state_r) cnt_nxt_s = 16'd0;
    else if (cnt_r != 16'hFFFF)  cnt_nxt_s = cnt_r + 16'd1;
    else                         cnt_nxt_s = cnt_r;

    case (state_r)
      S_IDLE: begin
        if (grant_s) begin
          tx_data_nxt_s    = pick_s ? data1 : data0;
          grant_id_nxt_s   = pick_s;
          last_grant_nxt_s = pick_s;
          ack0_nxt_s       = ~pick_s;
          ack1_nxt_s       = pick_s;
        end else begin
          tx_data_nxt_s    = tx_data_r;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_busy && start_to_s) err_nxt_s = 1'b1;
        else                        err_nxt_s = 1'b0;
      end
      S_WAIT_DONE: begin
        if (!tx_busy)       done_nxt_s = 1'b1;
        else if (done_to_s) err_nxt_s  = 1'b1;
        else                done_nxt_s = 1'b0;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 16'd0;
      last_grant_r <= 1'b1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      tx_data_r    <= 8'd0;
      tx_trig_r    <= 1'b0;
      grant_id_r   <= 1'b0;
      active_r     <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      ack0_r       <= ack0_nxt_s;
      ack1_r       <= ack1_nxt_s;
      tx_data_r    <= tx_data_nxt_s;
      tx_trig_r    <= tx_trig_nxt_s;
      grant_id_r   <= grant_id_nxt_s;
      active_r     <= active_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

  assign ack0     = ack0_r;
  assign ack1     = ack1_r;
  assign tx_data  = tx_data_r;
  assign tx_trig  = tx_trig_r;
  assign grant_id = grant_id_r;
  assign active   = active_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin scheduler that shares one UART transmit engine between two byte requesters.
- Accepts one byte at a time from either requester and drives the engine's data bus and falling-edge start strobe.
- Tracks the engine's busy (bps_start) flag until the frame completes, then enforces a guard gap before the next grant.
- Sits between the packet/echo sources and the UART transmitter in the serial datapath.

## Interface
Parameters:
- TRIG_LEN, 4: cycles tx_trig is held high before its falling edge; range 1..15.
- GAP_CYC, 2: idle guard cycles after each frame; range 0..255.
- START_TO, 16: max cycles to wait for tx_busy to rise after the trigger falls; 16-bit.
- DONE_TO, 40000: max cycles to wait for tx_busy to fall; 16-bit. 10-bit frame at 9600 baud on a 25 MHz clock is about 26040 cycles.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- req0, in, 1: requester 0 has a byte; hold until ack0.
- data0, in, 8: requester 0 byte; stable while req0 is high.
- ack0, out, 1: one-cycle pulse; data0 accepted.
- req1, in, 1: requester 1 has a byte.
- data1, in, 8: requester 1 byte.
- ack1, out, 1: one-cycle pulse; data1 accepted.
- tx_data, out, 8: byte presented to the engine.
- tx_trig, out, 1: start strobe; the engine starts on its falling edge.
- tx_busy, in, 1: engine busy flag (bps_start), high during a frame.
- grant_id, out, 1: requester owning the current/last frame.
- active, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse; frame completed normally.
- err, out, 1: one-cycle pulse; timeout abort.

## Operation
States: IDLE, TRIG, WAIT_BUSY, WAIT_DONE, GAP.

- IDLE:
  - Grant requires (req0|req1) and tx_busy==0.
  - One requester: it wins.
  - Both requesters: the one not equal to last_grant wins; last_grant resets to 1, so requester 0 wins first.
  - On grant: latch data into tx_data, set grant_id and last_grant, pulse ack for one cycle, go to TRIG.
- TRIG:
  - tx_trig=1 for exactly TRIG_LEN cycles (4-bit counter), then tx_trig=0 and go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy==1 → WAIT_DONE; the 16-bit counter is cleared on entry.
- WAIT_DONE:
  - tx_busy==0 → pulse done, go to GAP.
- GAP:
  - Count GAP_CYC cycles, then IDLE. GAP_CYC=0 gives one cycle in GAP.
- Data holding:
  - tx_data holds its value until the next grant. The engine samples it several cycles after the trigger falls.
  - Requesters may change data after ack.
  - A req still high after ack is a new request, eligible at the next IDLE.
- Ignored inputs:
  - A req that drops before grant is simply not served.
  - tx_busy outside WAIT_BUSY/WAIT_DONE is ignored, except for the IDLE grant gate.
- Reset values: ack0=ack1=0, tx_data=0, tx_trig=0, grant_id=0, active=0, done=0, err=0; state IDLE, counters 0, last_grant=1.
- Reset mid-frame: returns to IDLE next cycle. A tx_trig 1→0 caused by reset may start the engine; the engine shares reset, so this is accepted system behaviour.

## Timing
- req sampled high in IDLE at edge N:
  - Edge N+1: ack, tx_data, grant_id valid; tx_trig=1.
  - tx_trig high through N+TRIG_LEN; low from N+TRIG_LEN+1.
- WAIT_BUSY→WAIT_DONE: one cycle after tx_busy is sampled high.
- done: asserted the cycle after tx_busy is sampled low in WAIT_DONE.
- Minimum grant-to-grant spacing: TRIG_LEN + 1 + busy latency + frame + max(GAP_CYC,1) + 1 cycles.
- ack/done/err are registered; never high for two consecutive cycles.

## Configuration
Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_BUSY exceeding START_TO cycles, or WAIT_DONE exceeding DONE_TO cycles, pulses err.
  - The arbiter then goes to GAP with no done pulse.
  - Counter saturates; compare is "count == limit".
- Undefined:
  - No timeout logic; WAIT states wait indefinitely.
  - err is tied to 0.
  - START_TO/DONE_TO are unused.

## Test plan
- Single byte: req0=1, data0=0xA5, busy model rises 3 cycles after trig falls and stays high 100 cycles → ack0 at N+1; tx_trig high 4 cycles; tx_data=0xA5; done once; grant_id=0.
- Simultaneous requests: req0=req1=1 held for 4 frames, data0=0x11, data1=0x22 → grants alternate 0,1,0,1; tx_data alternates 0x11/0x22.
- Busy gate: tx_busy=1 in IDLE with req1=1 → no ack1 until tx_busy=0; ack1 one cycle after.
- Timeout (macro defined): busy model never rises → err at 16 cycles after WAIT_BUSY entry; no done; next request served after GAP.
- Timeout (macro defined): busy stuck high after rising → err after DONE_TO cycles.
- Reset mid-frame: assert rst for 1 cycle during WAIT_DONE → next cycle all outputs at reset values; next grant goes to requester 0.
